counter_checker: RTL and testbench
==================================

# counter_checker

Passive checker for the up-counter: watches a counter's output bus together with the same `clear`/`enable` stimulus the counter receives and verifies the count sequence cycle by cycle. It keeps a reference model of the counter, flags every mismatch, counts errors, and captures the first bad sample. It sits beside any counter instance in a bench or SoC as a self-check monitor and never drives the counter.

## Interface
- `WIDTH`, 4: width of the observed count; wraps modulo 2^WIDTH.
- `ERR_W`, 8: width of the saturating error counter.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: the counter's synchronous clear (active-high), sampled as the counter samples it.
- `enable`  in  1: the counter's count enable.
- `count_in`  in  WIDTH: the counter's registered output.
- `clr_status`  in  1: synchronous clear of the error status (`err_count`, `sticky_err`, first-capture).
- `locked`  out  1: the reference model is valid and comparisons are active.
- `error`  out  1: one-cycle pulse per detected mismatch.
- `sticky_err`  out  1: set on the first mismatch; held until `clr_status` or reset.
- `err_count`  out  ERR_W: number of mismatches, saturating at 2^ERR_W-1.
- `first_exp`  out  WIDTH: expected value at the first mismatch.
- `first_got`  out  WIDTH: observed value at the first mismatch.

## Operation
- Model next value: `nxt(v) = clear ? 0 : enable ? v+1 (mod 2^WIDTH) : v`.
- States:
  - UNLOCKED: no compare. At each edge, `exp <= nxt(count_in)` and the state goes to LOCKED.
  - LOCKED: at each edge, compare `count_in` with `exp`, then `exp <= nxt(exp)`.
    - Match: stay in LOCKED.
    - Mismatch: pulse `error`, record the error, go to UNLOCKED. A stuck or skipped counter reseeds and is reported once per divergence, not every cycle.
- `clear` sampled high in any state: the compare for that edge still happens if the state is LOCKED; then `exp <= 0` and the next state is LOCKED.
- Recording an error:
  - `err_count` increments, saturating at its maximum.
  - If `sticky_err` is 0: capture `first_exp`/`first_got` and set `sticky_err`.
- `clr_status` at the same edge as a mismatch: status clears, then the new error is recorded. Result: `err_count`=1, `sticky_err`=1, first-capture loaded with the new mismatch.
- `clr_status` does not affect the state, `exp`, or `locked`.

## Timing
- Reset (`reset_n` low, asynchronous, with no clock edge needed):
  - State goes to UNLOCKED and `exp`=0.
  - All outputs go to 0: `locked`, `error`, `sticky_err`, `err_count`, `first_exp`, `first_got`.
- After `reset_n` deasserts:
  - With `clear`=0: `locked` rises after the first edge (seed).
  - With `clear`=1: the model is also LOCKED after that first edge.
- All outputs are registered. `error`, status, and `locked` update one edge after the edge that sampled the mismatching `count_in`.
- `locked` drops for exactly one cycle after each mismatch (the reseed cycle) unless `clear` is high.
- Alignment: the inputs at edge t determine the counter value seen at edge t+1. The checker compares `count_in`@t+1 against `nxt` computed @t. No extra latency on `count_in`.
- Wrap: 2^WIDTH-1 followed by 0 with `enable` high is a match.
- `reset_n` asserted mid-run: all state and outputs are discarded immediately. There is no partial capture.

## Structure
- Shared package `counter_pkg`:
  - State enum `chk_state_t` {UNLOCKED, LOCKED}.
  - Default `COUNTER_WIDTH`=4, also used by the counter.
- One natural sub-module, `counter_model`: a registered reference model with inputs `clk`, `reset_n`, `clear`, `enable`, `load`, and `load_val`, and output `exp`. The checker drives `load` in UNLOCKED.
- Error and first-capture logic is inline in `counter_checker`. Expected size is about 150 RTL lines.

## Test plan
- Reset and lock: hold `reset_n`=0 for 3 edges, then release with `count_in`=0, `clear`=0, `enable`=0.
  - During reset all outputs are 0.
  - `locked`=1 after the first edge; no `error`.
- Clean run: drive a real counter with `clear` for 1 cycle, then `enable` for 20 cycles (wraps 15→0).
  - `error` never pulses; `err_count`=0; `locked` stays 1.
- Stuck counter: after lock with `exp`=6, force `count_in`=5 and hold `enable`=1.
  - One edge later: `error` pulse, `first_exp`=6, `first_got`=5, `err_count`=1.
  - `err_count`=2 two cycles later.
  - `first_*` unchanged thereafter.
- Saturation: `ERR_W`=2, inject 5 separate mismatches.
  - `err_count` ends at 3; `sticky_err`=1.
- Simultaneous events:
  - A mismatch with `clear`=1 on the same edge: counted, and then `locked`=1 with `exp`=0.
  - A mismatch with `clr_status`=1 on the same edge: `err_count`=1, and the first-capture holds the new values.
- Asynchronous reset mid-run: with `err_count`=3, pull `reset_n` low between edges.
  - All outputs read 0 before the next rising edge.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg
// Definitions shared by the up-counter and its checker.
//   COUNTER_WIDTH : default width of the count bus
//   chk_state_t   : checker lock state (UNLOCKED while reseeding, LOCKED while comparing)
package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } chk_state_t;

endpackage

// File: rtl/counter_model.sv
// counter_model
// Registered reference model of the up-counter. It holds the value the
// counter is expected to show at the next rising edge.
//   clk      : clock, all updates on the rising edge
//   reset_n  : asynchronous active-low reset, clears exp to 0
//   clear    : counter's synchronous clear, forces exp to 0
//   enable   : counter's count enable
//   load     : take load_val as the current value instead of exp (reseed)
//   load_val : value to reseed from, normally the observed count
//   exp      : expected counter value for the next edge
module counter_model
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] exp
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] base;

    // The next value is derived either from the observed count (when
    // reseeding) or from the model's own previous prediction.
    assign base = load ? load_val : exp;

    // Same next-value rule as the counter: clear wins, then increment
    // modulo 2^WIDTH when enabled, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp <= '0;
        end else if (clear) begin
            exp <= '0;
        end else if (enable) begin
            exp <= base + ONE;
        end else begin
            exp <= base;
        end
    end

endmodule

// File: rtl/counter_checker.sv
// counter_checker
// Passive monitor for the up-counter. It follows the counter with a
// reference model, compares every cycle once locked, and reports errors.
//   clk        : clock, all state changes on the rising edge
//   reset_n    : asynchronous active-low reset
//   clear      : counter's synchronous clear
//   enable     : counter's count enable
//   count_in   : counter's registered output
//   clr_status : synchronous clear of err_count, sticky_err and first capture
//   locked     : model is valid and comparisons are active
//   error      : one-cycle pulse per mismatch
//   sticky_err : set at the first mismatch, held until clr_status or reset
//   err_count  : saturating mismatch count
//   first_exp  : expected value at the first mismatch
//   first_got  : observed value at the first mismatch
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_status,
    output logic             locked,
    output logic             error,
    output logic             sticky_err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    chk_state_t       state;
    logic [WIDTH-1:0] exp;
    logic             load;
    logic             mismatch;
    logic [ERR_W-1:0] cnt_base;

    // While unlocked the model reseeds from the observed count instead of
    // trusting its own (diverged) prediction.
    assign load     = (state == UNLOCKED);
    assign mismatch = (state == LOCKED) && (count_in != exp);
    assign locked   = (state == LOCKED);

    counter_model #(
        .WIDTH(WIDTH)
    ) u_model (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .enable   (enable),
        .load     (load),
        .load_val (count_in),
        .exp      (exp)
    );

    // A mismatch drops lock for one reseed cycle so a stuck or skipping
    // counter is reported once per divergence. A clear makes the next value
    // known (zero), so it locks regardless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
        end else if (clear || !mismatch) begin
            state <= LOCKED;
        end else begin
            state <= UNLOCKED;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else begin
            error <= mismatch;
        end
    end

    // clr_status is applied first so a mismatch on the same edge is counted
    // against the freshly cleared status.
    assign cnt_base = clr_status ? '0 : err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (mismatch && (cnt_base != '1)) begin
            err_count <= cnt_base + ERR_ONE;
        end else begin
            err_count <= cnt_base;
        end
    end

    // First-capture: the later assignment overrides the clear when a
    // mismatch lands on the same edge as clr_status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_err <= 1'b0;
            first_exp  <= '0;
            first_got  <= '0;
        end else begin
            if (clr_status) begin
                sticky_err <= 1'b0;
                first_exp  <= '0;
                first_got  <= '0;
            end
            if (mismatch && (clr_status || !sticky_err)) begin
                sticky_err <= 1'b1;
                first_exp  <= exp;
                first_got  <= count_in;
            end
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker
// Bench for counter_checker. Two instances share the same stimulus: one with
// the default 8-bit error counter and one with a 2-bit counter to reach
// saturation quickly.
module tb_counter_checker;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       enable;
    logic [3:0] count_in;
    logic       clr_status;

    logic       locked,     locked_s;
    logic       error,      error_s;
    logic       sticky_err, sticky_err_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;
    logic [3:0] first_exp,  first_exp_s;
    logic [3:0] first_got,  first_got_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       locked;
        logic       error;
        logic       sticky;
        logic [7:0] cnt;
        logic [1:0] cnt_sat;
        logic [3:0] fexp;
        logic [3:0] fgot;
    } expect_t;

    expect_t sb_queue[$];

    // Reference state, written from the counter's documented behaviour.
    logic       m_locked;
    logic [3:0] m_exp;
    logic       m_sticky;
    int         m_cnt;
    int         m_cnt_sat;
    logic [3:0] m_fexp;
    logic [3:0] m_fgot;

    logic [3:0] real_cnt;

    counter_checker #(
        .WIDTH(4),
        .ERR_W(8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .enable     (enable),
        .count_in   (count_in),
        .clr_status (clr_status),
        .locked     (locked),
        .error      (error),
        .sticky_err (sticky_err),
        .err_count  (err_count),
        .first_exp  (first_exp),
        .first_got  (first_got)
    );

    counter_checker #(
        .WIDTH(4),
        .ERR_W(2)
    ) dut_sat (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .enable     (enable),
        .count_in   (count_in),
        .clr_status (clr_status),
        .locked     (locked_s),
        .error      (error_s),
        .sticky_err (sticky_err_s),
        .err_count  (err_count_s),
        .first_exp  (first_exp_s),
        .first_got  (first_got_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic resetModel();
        m_locked  = 1'b0;
        m_exp     = 4'd0;
        m_sticky  = 1'b0;
        m_cnt     = 0;
        m_cnt_sat = 0;
        m_fexp    = 4'd0;
        m_fgot    = 4'd0;
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_locked"},    {31'd0, locked},     32'd0);
        checkOutput({tag, "_error"},     {31'd0, error},      32'd0);
        checkOutput({tag, "_sticky"},    {31'd0, sticky_err}, 32'd0);
        checkOutput({tag, "_errCount"},  {24'd0, err_count},  32'd0);
        checkOutput({tag, "_firstExp"},  {28'd0, first_exp},  32'd0);
        checkOutput({tag, "_firstGot"},  {28'd0, first_got},  32'd0);
        checkOutput({tag, "_errCountS"}, {30'd0, err_count_s}, 32'd0);
        checkOutput({tag, "_lockedS"},   {31'd0, locked_s},   32'd0);
    endtask

    // Predict the outputs for the coming edge from the current inputs, push
    // the prediction, clock once and compare against what the DUTs show.
    task automatic applyStimulus();
        expect_t    e;
        expect_t    o;
        logic       mism;
        logic [3:0] base;
        mism = m_locked && (count_in != m_exp);
        if (clr_status) begin
            m_cnt     = 0;
            m_cnt_sat = 0;
            m_sticky  = 1'b0;
            m_fexp    = 4'd0;
            m_fgot    = 4'd0;
        end
        if (mism) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_sat < 3) m_cnt_sat++;
            if (!m_sticky) begin
                m_sticky = 1'b1;
                m_fexp   = m_exp;
                m_fgot   = count_in;
            end
        end
        base     = m_locked ? m_exp : count_in;
        m_exp    = clear ? 4'd0 : (enable ? base + 4'd1 : base);
        m_locked = clear || !mism;
        e.locked  = m_locked;
        e.error   = mism;
        e.sticky  = m_sticky;
        e.cnt     = m_cnt[7:0];
        e.cnt_sat = m_cnt_sat[1:0];
        e.fexp    = m_fexp;
        e.fgot    = m_fgot;
        sb_queue.push_back(e);
        @(posedge clk);
        #1;
        o = sb_queue.pop_front();
        checkOutput("locked",    {31'd0, locked},      {31'd0, o.locked});
        checkOutput("error",     {31'd0, error},       {31'd0, o.error});
        checkOutput("sticky",    {31'd0, sticky_err},  {31'd0, o.sticky});
        checkOutput("errCount",  {24'd0, err_count},   {24'd0, o.cnt});
        checkOutput("firstExp",  {28'd0, first_exp},   {28'd0, o.fexp});
        checkOutput("firstGot",  {28'd0, first_got},   {28'd0, o.fgot});
        checkOutput("errCountS", {30'd0, err_count_s}, {30'd0, o.cnt_sat});
        checkOutput("stickyS",   {31'd0, sticky_err_s}, {31'd0, o.sticky});
    endtask

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        enable     = 1'b0;
        count_in   = 4'd0;
        clr_status = 1'b0;
        resetModel();

        // Reset held for three edges, then seed from count_in=0.
        repeat (3) begin
            @(posedge clk);
            #1;
            checkZeros("reset");
        end
        reset_n = 1'b1;
        applyStimulus();
        checkOutput("seedLocked", {31'd0, locked}, 32'd1);
        checkOutput("seedError",  {31'd0, error},  32'd0);

        // Clean run against a well-behaved counter, including the 15->0 wrap.
        real_cnt = 4'd0;
        clear    = 1'b1;
        count_in = real_cnt;
        applyStimulus();
        real_cnt = 4'd0;
        clear    = 1'b0;
        enable   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            count_in = real_cnt;
            applyStimulus();
            real_cnt = real_cnt + 4'd1;
        end
        checkOutput("cleanErrCount", {24'd0, err_count}, 32'd0);
        checkOutput("cleanLocked",   {31'd0, locked},    32'd1);

        // Advance to exp=6, then hold the counter stuck at 5.
        for (int i = 0; i < 2; i++) begin
            count_in = real_cnt;
            applyStimulus();
            real_cnt = real_cnt + 4'd1;
        end
        count_in = 4'd5;
        applyStimulus();
        checkOutput("stuckError",    {31'd0, error},     32'd1);
        checkOutput("stuckFirstExp", {28'd0, first_exp}, 32'd6);
        checkOutput("stuckFirstGot", {28'd0, first_got}, 32'd5);
        checkOutput("stuckCount1",   {24'd0, err_count}, 32'd1);
        checkOutput("stuckUnlocked", {31'd0, locked},    32'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("stuckCount2",   {24'd0, err_count}, 32'd2);
        applyStimulus();
        checkOutput("stuckHoldExp",  {28'd0, first_exp}, 32'd6);
        checkOutput("stuckHoldGot",  {28'd0, first_got}, 32'd5);

        // Three more divergences: five in total saturates the 2-bit counter.
        repeat (5) applyStimulus();
        checkOutput("satCount",   {30'd0, err_count_s},  32'd3);
        checkOutput("satSticky",  {31'd0, sticky_err_s}, 32'd1);
        checkOutput("wideCount5", {24'd0, err_count},    32'd5);

        // Reseed, then a mismatch coincident with clear.
        applyStimulus();
        count_in = 4'd9;
        clear    = 1'b1;
        applyStimulus();
        checkOutput("clrMismError",  {31'd0, error},     32'd1);
        checkOutput("clrMismLocked", {31'd0, locked},    32'd1);
        checkOutput("clrMismCount",  {24'd0, err_count}, 32'd6);
        count_in = 4'd0;
        clear    = 1'b0;
        enable   = 1'b0;
        applyStimulus();
        checkOutput("afterClrError", {31'd0, error}, 32'd0);

        // Mismatch coincident with clr_status.
        count_in   = 4'd3;
        clr_status = 1'b1;
        applyStimulus();
        clr_status = 1'b0;
        checkOutput("clrStatCount",    {24'd0, err_count}, 32'd1);
        checkOutput("clrStatSticky",   {31'd0, sticky_err}, 32'd1);
        checkOutput("clrStatFirstExp", {28'd0, first_exp}, 32'd0);
        checkOutput("clrStatFirstGot", {28'd0, first_got}, 32'd3);

        // Two more divergences to bring the count to 3.
        applyStimulus();
        count_in = 4'd7;
        applyStimulus();
        applyStimulus();
        count_in = 4'd1;
        applyStimulus();
        checkOutput("preRstCount", {24'd0, err_count}, 32'd3);

        // Asynchronous reset between edges.
        #2;
        reset_n = 1'b0;
        resetModel();
        #1;
        checkZeros("asyncRst");
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        clear    = 1'b1;
        count_in = 4'd9;
        applyStimulus();
        checkOutput("clearSeedLocked", {31'd0, locked}, 32'd1);
        clear    = 1'b0;
        enable   = 1'b1;
        count_in = 4'd0;
        applyStimulus();
        checkOutput("clearSeedError", {31'd0, error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
